// File: rtl/bp_me_axil_client_lite.sv
// bp_me_axil_client_lite
//
// AXI4-Lite slave that turns each host read/write into one single-beat BedRock
// uncached memory command and turns the BedRock response back into an R or B
// response. Exactly one transaction is in flight at a time.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge where
// valid and ready are both high. A valid, once raised, stays high with stable
// payload until that transfer happens.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   did_i, lce_id_i           source ids copied into every command header
//   mem_cmd_*                 BedRock command out (header, data, valid/ready, last)
//   mem_resp_*                BedRock response in (header, data, valid/ready, last)
//   s_axil_*                  AXI4-Lite slave (AW, W, B, AR, R channels)
//   state_o                   current FSM state (debug visibility)
//
// Command header layout, MSB to LSB:
//   {did, lce_id, size[2:0], addr[paddr_width_p-1:0], msg_type[3:0]}
//   msg_type: uc_rd = 4'b0010, uc_wr = 4'b0011
//   size:     log2(bytes), i.e. 0 = 1 byte ... 3 = 8 bytes

module bp_me_axil_client_lite #(
    parameter int paddr_width_p     = 32,
    parameter int did_width_p       = 4,
    parameter int lce_id_width_p    = 4,
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 64,
    localparam int hdr_width_lp     = did_width_p + lce_id_width_p + 3 + paddr_width_p + 4,
    localparam int strb_width_lp    = axil_data_width_p / 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic [did_width_p-1:0]        did_i,
    input  logic [lce_id_width_p-1:0]     lce_id_i,

    output logic [hdr_width_lp-1:0]       mem_cmd_header_o,
    output logic [axil_data_width_p-1:0]  mem_cmd_data_o,
    output logic                          mem_cmd_v_o,
    input  logic                          mem_cmd_ready_and_i,
    output logic                          mem_cmd_last_o,

    input  logic [hdr_width_lp-1:0]       mem_resp_header_i,
    input  logic [axil_data_width_p-1:0]  mem_resp_data_i,
    input  logic                          mem_resp_v_i,
    output logic                          mem_resp_ready_and_o,
    input  logic                          mem_resp_last_i,

    input  logic [axil_addr_width_p-1:0]  s_axil_awaddr_i,
    input  logic [2:0]                    s_axil_awprot_i,
    input  logic                          s_axil_awvalid_i,
    output logic                          s_axil_awready_o,

    input  logic [axil_data_width_p-1:0]  s_axil_wdata_i,
    input  logic [strb_width_lp-1:0]      s_axil_wstrb_i,
    input  logic                          s_axil_wvalid_i,
    output logic                          s_axil_wready_o,

    output logic [1:0]                    s_axil_bresp_o,
    output logic                          s_axil_bvalid_o,
    input  logic                          s_axil_bready_i,

    input  logic [axil_addr_width_p-1:0]  s_axil_araddr_i,
    input  logic [2:0]                    s_axil_arprot_i,
    input  logic                          s_axil_arvalid_i,
    output logic                          s_axil_arready_o,

    output logic [axil_data_width_p-1:0]  s_axil_rdata_o,
    output logic [1:0]                    s_axil_rresp_o,
    output logic                          s_axil_rvalid_o,
    input  logic                          s_axil_rready_i,

    output logic [2:0]                    state_o
);

    localparam int lg_bytes_lp = $clog2(strb_width_lp);

    localparam logic [3:0] uc_rd_lp = 4'b0010;
    localparam logic [3:0] uc_wr_lp = 4'b0011;
    localparam logic [1:0] okay_lp  = 2'b00;
    localparam logic [1:0] slverr_lp = 2'b10;

    if (!(axil_data_width_p == 32 || axil_data_width_p == 64)) begin : g_bad_data_width
        $error("axil_data_width_p must be 32 or 64");
    end
    if (axil_addr_width_p < paddr_width_p) begin : g_bad_addr_width
        $error("axil_addr_width_p must be >= paddr_width_p");
    end

    typedef enum logic [2:0] {
        S_READY     = 3'd0,
        S_SEND_CMD  = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_SEND_B    = 3'd3,
        S_SEND_R    = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic                           last_grant_q, last_grant_d;   // 1 = read won last
    logic                           is_read_q, is_read_d;
    logic [hdr_width_lp-1:0]        hdr_q, hdr_d;
    logic [axil_data_width_p-1:0]   cmd_data_q, cmd_data_d;
    logic [axil_data_width_p-1:0]   resp_data_q, resp_data_d;
    logic [1:0]                     bresp_q, bresp_d;

    logic                           grant_w, grant_r;
    logic                           strb_ok;
    logic [lg_bytes_lp-1:0]         strb_off;
    logic [2:0]                     strb_size;

    // Strobe decode: accept only a contiguous run of 2^s bytes starting at an
    // offset that is a multiple of its own length.
    always_comb begin
        strb_ok   = 1'b0;
        strb_off  = '0;
        strb_size = '0;
        for (int s = 0; s <= lg_bytes_lp; s++) begin
            for (int o = 0; o < strb_width_lp; o++) begin
                if (((o % (1 << s)) == 0) && ((o + (1 << s)) <= strb_width_lp) &&
                    (s_axil_wstrb_i == strb_width_lp'(((1 << (1 << s)) - 1) << o))) begin
                    strb_ok   = 1'b1;
                    strb_off  = lg_bytes_lp'(o);
                    strb_size = 3'(s);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        is_read_d    = is_read_q;
        hdr_d        = hdr_q;
        cmd_data_d   = cmd_data_q;
        resp_data_d  = resp_data_q;
        bresp_d      = bresp_q;
        grant_w      = 1'b0;
        grant_r      = 1'b0;

        case (state_q)
            S_READY: begin
                // Alternate when both directions compete; AW is only taken with W.
                if (s_axil_awvalid_i && s_axil_wvalid_i && s_axil_arvalid_i) begin
                    grant_w = last_grant_q;
                    grant_r = !last_grant_q;
                end else begin
                    grant_w = s_axil_awvalid_i && s_axil_wvalid_i;
                    grant_r = s_axil_arvalid_i;
                end

                if (grant_w) begin
                    is_read_d = 1'b0;
                    if (s_axil_wstrb_i == '0) begin
                        bresp_d = okay_lp;
                        state_d = S_SEND_B;
                    end else if (strb_ok) begin
                        hdr_d = {did_i, lce_id_i, strb_size,
                                 s_axil_awaddr_i[paddr_width_p-1:lg_bytes_lp], strb_off,
                                 uc_wr_lp};
                        cmd_data_d = s_axil_wdata_i >> {strb_off, 3'b000};
                        state_d    = S_SEND_CMD;
                    end else begin
                        bresp_d = slverr_lp;
                        state_d = S_SEND_B;
                    end
                end else if (grant_r) begin
                    is_read_d  = 1'b1;
                    hdr_d      = {did_i, lce_id_i, 3'(lg_bytes_lp),
                                  s_axil_araddr_i[paddr_width_p-1:lg_bytes_lp],
                                  {lg_bytes_lp{1'b0}}, uc_rd_lp};
                    cmd_data_d = '0;
                    state_d    = S_SEND_CMD;
                end
            end

            S_SEND_CMD: begin
                if (mem_cmd_ready_and_i) begin
                    state_d = S_WAIT_RESP;
                end
            end

            S_WAIT_RESP: begin
                if (mem_resp_v_i) begin
                    resp_data_d = mem_resp_data_i;
                    bresp_d     = okay_lp;
                    state_d     = is_read_q ? S_SEND_R : S_SEND_B;
                end
            end

            S_SEND_B: begin
                if (s_axil_bready_i) begin
                    last_grant_d = 1'b0;
                    state_d      = S_READY;
                end
            end

            S_SEND_R: begin
                if (s_axil_rready_i) begin
                    last_grant_d = 1'b1;
                    state_d      = S_READY;
                end
            end

            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_READY;
            last_grant_q <= 1'b1;
            is_read_q    <= 1'b0;
            hdr_q        <= '0;
            cmd_data_q   <= '0;
            resp_data_q  <= '0;
            bresp_q      <= okay_lp;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            is_read_q    <= is_read_d;
            hdr_q        <= hdr_d;
            cmd_data_q   <= cmd_data_d;
            resp_data_q  <= resp_data_d;
            bresp_q      <= bresp_d;
        end
    end

    // Readies follow valid combinationally, so hold them low while reset is
    // asserted even though the state register already reads READY.
    assign s_axil_awready_o     = grant_w && reset_n_i;
    assign s_axil_wready_o      = grant_w && reset_n_i;
    assign s_axil_arready_o     = grant_r && reset_n_i;

    assign s_axil_bvalid_o      = (state_q == S_SEND_B);
    assign s_axil_bresp_o       = bresp_q;
    assign s_axil_rvalid_o      = (state_q == S_SEND_R);
    assign s_axil_rdata_o       = resp_data_q;
    assign s_axil_rresp_o       = okay_lp;

    assign mem_cmd_v_o          = (state_q == S_SEND_CMD);
    assign mem_cmd_last_o       = mem_cmd_v_o;
    assign mem_cmd_header_o     = hdr_q;
    assign mem_cmd_data_o       = cmd_data_q;
    assign mem_resp_ready_and_o = (state_q == S_WAIT_RESP);

    assign state_o              = state_q;

    // Protection bits, response header/last and sub-word address bits carry no
    // information for this bridge.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axil_awprot_i, s_axil_arprot_i, mem_resp_header_i,
                             mem_resp_last_i, s_axil_awaddr_i, s_axil_araddr_i};

endmodule
